freq_to_code: RTL

- Frequency-to-digital converter; the inverse of the DCO path (code -> frequency).
- Counts rising edges of an asynchronous oscillator input over a fixed window of reference-clock cycles and outputs the edge count as a WIDTH-bit code.
- Used to close loops around dco_lin / dco_exp: it measures the oscillator and returns a code comparable to the DCO input code.
- Sits between an oscillator output and digital control logic.

---
 rtl/freq_to_code.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/freq_to_code.sv
// ---------------------------------------------------------------------------
// freq_to_code
//   Frequency-to-digital converter. Counts rising edges of an asynchronous
//   oscillator over a fixed window of WINDOW reference-clock cycles and
//   returns the count as a WIDTH-bit code. The code is directly comparable
//   to the input code of the matching DCO, so the block can close a loop
//   around it.
//
// Parameters
//   WIDTH       width of the output code and of the edge counter
//   WINDOW      measurement window in clk cycles (>= 2)
//   SYNC_STAGES synchronizer depth on osc_in (>= 2)
//
// Ports
//   clk         reference clock, sole clock domain
//   rst_n       synchronous reset, active-low
//   osc_in      oscillator under measurement, asynchronous to clk
//   start       one-shot measurement request, honoured only in IDLE
//   continuous  restart automatically after each accepted result
//   code        measured edge count (holds until the next result loads)
//   code_valid  code holds a new, unaccepted result
//   code_ready  consumer accepts code when code_valid & code_ready
//   overflow    result saturated at 2^WIDTH-1, qualified by code_valid
//   busy        FSM is not in IDLE
//
// Accuracy requires f_osc < f_clk/2; faster inputs alias undetected.
// ---------------------------------------------------------------------------
module freq_to_code #(
  parameter int WIDTH       = 13,
  parameter int WINDOW      = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc_in,
  input  logic             start,
  input  logic             continuous,
  output logic [WIDTH-1:0] code,
  output logic             code_valid,
  input  logic             code_ready,
  output logic             overflow,
  output logic             busy
);

  localparam int              WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    HOLD
  } state_e;

  state_e                 state_q,      state_d;
  logic [SYNC_STAGES-1:0] sync_q,       sync_d;
  logic                   prev_q,       prev_d;
  logic [WIDTH-1:0]       edge_cnt_q,   edge_cnt_d;
  logic                   sat_q,        sat_d;
  logic [WIN_W-1:0]       win_cnt_q,    win_cnt_d;
  logic [WIDTH-1:0]       code_q,       code_d;
  logic                   code_valid_q, code_valid_d;
  logic                   overflow_q,   overflow_d;
  logic                   busy_q,       busy_d;

  logic                   synced;
  logic                   rise;
  logic [WIDTH-1:0]       cnt_next;
  logic                   sat_next;

  // Oldest synchronizer stage is the only one safe to use as logic.
  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev_q;

  // Saturating count including this cycle's rise; an edge arriving while
  // already at the ceiling sets the sticky saturation flag instead of
  // wrapping.
  always_comb begin
    cnt_next = edge_cnt_q;
    sat_next = sat_q;
    if (rise) begin
      if (edge_cnt_q == CNT_MAX) sat_next = 1'b1;
      else                       cnt_next = edge_cnt_q + WIDTH'(1);
    end
  end

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    sync_d       = {sync_q[SYNC_STAGES-2:0], osc_in};
    prev_d       = synced;
    edge_cnt_d   = edge_cnt_q;
    sat_d        = sat_q;
    win_cnt_d    = win_cnt_q;
    code_d       = code_q;
    code_valid_d = code_valid_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start || continuous) state_d = ARM;
      end

      // A rise seen during ARM is deliberately dropped by the clear.
      ARM: begin
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        win_cnt_d  = '0;
        state_d    = MEASURE;
      end

      MEASURE: begin
        edge_cnt_d = cnt_next;
        sat_d      = sat_next;
        win_cnt_d  = win_cnt_q + WIN_W'(1);
        // The last window cycle's rise is folded into the result directly.
        if (win_cnt_q == WIN_LAST) begin
          code_d       = cnt_next;
          overflow_d   = sat_next;
          code_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end

      HOLD: begin
        if (code_ready) begin
          code_valid_d = 1'b0;
          overflow_d   = 1'b0;
          state_d      = continuous ? ARM : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      prev_q       <= 1'b0;
      edge_cnt_q   <= '0;
      sat_q        <= 1'b0;
      win_cnt_q    <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      edge_cnt_q   <= edge_cnt_d;
      sat_q        <= sat_d;
      win_cnt_q    <= win_cnt_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule
